hdsiso8_prbs_checker: RTL and testbench

HDSISO8_PRBS_CHECKER -- requirements
Module: hdsiso8_prbs_checker

---
 rtl/hdsiso8_pkg.sv | 20 ++
 rtl/hdsiso8_prbs15_core.sv | 28 ++
 rtl/hdsiso8_prbs_checker.sv | 132 +++++++++++++
 tb/tb_hdsiso8_prbs_checker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdsiso8_pkg.sv
// Shared PRBS15 definitions for the hdsiso8 generator and checker.
// Both sides must agree on width, taps and the checker state encoding.
package hdsiso8_pkg;

  localparam int PRBS_W = 15;
  localparam int TAP_A  = 14;
  localparam int TAP_B  = 13;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  // x^15 + x^14 + 1, Fibonacci form: next bit from the two oldest stages.
  function automatic logic prbs_predict(input logic [PRBS_W-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/hdsiso8_prbs15_core.sv
// PRBS15 predictor and shift register. use_din selects whether the received
// bit (acquisition) or the predicted bit (free-run) is shifted in.
module hdsiso8_prbs15_core
  import hdsiso8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              use_din,
  input  logic              d_in,
  output logic              pred,
  output logic [PRBS_W-1:0] s_next
);

  logic [PRBS_W-1:0] s;

  assign pred   = prbs_predict(s);
  assign s_next = {s[PRBS_W-2:0], (use_din ? d_in : pred)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
    end else if (shift_en) begin
      s <= s_next;
    end
  end

endmodule

// File: rtl/hdsiso8_prbs_checker.sv
// PRBS15 receive checker: HUNT fills the register, SYNC confirms LOCK_CNT
// matches, LOCKED free-runs and counts errors with a windowed loss detector.
module hdsiso8_prbs_checker
  import hdsiso8_pkg::*;
#(
  parameter int LOCK_CNT  = 16,
  parameter int LOSS_ERRS = 8,
  parameter int WINDOW    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_en,
  input  logic       d_in,
  input  logic       clr_cnt,
  output logic       locked,
  output logic [1:0] state,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic       period
);

  localparam int MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int ERR_W   = (LOSS_ERRS > 1) ? $clog2(LOSS_ERRS) : 1;

  state_t             state_q, state_nxt;
  logic [3:0]         fill_q, fill_nxt;
  logic [MATCH_W-1:0] match_q, match_nxt;
  logic [WIN_W-1:0]   win_q, win_nxt;
  logic [ERR_W-1:0]   win_err_q, win_err_nxt;

  logic              pred;
  logic [PRBS_W-1:0] s_next;
  logic              in_lock;
  logic              err_hit;

  assign in_lock = (state_q == ST_LOCKED);
  assign err_hit = bit_en && in_lock && (d_in != pred);
  assign locked  = in_lock;
  assign state   = state_q;

  hdsiso8_prbs15_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (bit_en),
    .use_din  (!in_lock),
    .d_in     (d_in),
    .pred     (pred),
    .s_next   (s_next)
  );

  always_comb begin
    state_nxt   = state_q;
    fill_nxt    = fill_q;
    match_nxt   = match_q;
    win_nxt     = win_q;
    win_err_nxt = win_err_q;
    if (bit_en) begin
      unique case (state_q)
        ST_HUNT: begin
          if (fill_q == 4'(PRBS_W - 1)) begin
            fill_nxt = '0;
            // An all-zero register is the LFSR lock-up state; refill instead.
            if (s_next != '0) begin
              state_nxt = ST_SYNC;
              match_nxt = '0;
            end
          end else begin
            fill_nxt = fill_q + 4'd1;
          end
        end
        ST_SYNC: begin
          if (d_in == pred) begin
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_nxt   = ST_LOCKED;
              win_nxt     = '0;
              win_err_nxt = '0;
            end else begin
              match_nxt = match_q + 1'b1;
            end
          end else begin
            state_nxt = ST_HUNT;
            fill_nxt  = '0;
            match_nxt = '0;
          end
        end
        ST_LOCKED: begin
          win_nxt = (win_q == WIN_W'(WINDOW - 1)) ? '0 : win_q + 1'b1;
          if (err_hit && (win_err_q == ERR_W'(LOSS_ERRS - 1))) begin
            state_nxt   = ST_HUNT;
            fill_nxt    = '0;
            win_nxt     = '0;
            win_err_nxt = '0;
          end else if (win_q == WIN_W'(WINDOW - 1)) begin
            // The wrapping bit's error still belonged to the old window.
            win_err_nxt = '0;
          end else if (err_hit) begin
            win_err_nxt = win_err_q + 1'b1;
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HUNT;
      fill_q    <= '0;
      match_q   <= '0;
      win_q     <= '0;
      win_err_q <= '0;
      err_pulse <= 1'b0;
      period    <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_nxt;
      fill_q    <= fill_nxt;
      match_q   <= match_nxt;
      win_q     <= win_nxt;
      win_err_q <= win_err_nxt;
      err_pulse <= err_hit;
      period    <= bit_en && in_lock && (s_next == '1);
      if (clr_cnt) begin
        err_count <= '0;
      end else if (err_hit && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hdsiso8_prbs_checker.sv
// Directed bench for hdsiso8_prbs_checker: vector tables for acquisition,
// hand-written sequences for errors, windows, saturation and async reset.
module tb_hdsiso8_prbs_checker;

  typedef struct {
    logic       en;
    logic       d;
    logic       clr;
    logic [1:0] exp_state;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_en;
  logic       d_in;
  logic       clr_cnt;
  logic       locked;
  logic [1:0] state;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       period;

  int          checks = 0;
  int          passes = 0;
  int          errs = 0;
  logic [14:0] g;
  logic [7:0]  exp_q[$];

  vec_t zvec[24];
  vec_t lvec[31];

  hdsiso8_prbs_checker #(.LOCK_CNT(16), .LOSS_ERRS(8), .WINDOW(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bit_en),
    .d_in      (d_in),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .state     (state),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .period    (period)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL timeout: simulation exceeded time budget, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bit_en  = 1'b0;
    d_in    = 1'b0;
    clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    g = 15'h7FFF;
    errs = 0;
    exp_q.delete();
  endtask

  // driver tasks
  task automatic tick(input logic en, input logic d, input logic clr);
    bit_en  = en;
    d_in    = d;
    clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic gen_bit();
    logic b;
    b = g[14] ^ g[13];
    g = {g[13:0], b};
    return b;
  endfunction

  task automatic send(input logic flip);
    logic b;
    b = gen_bit();
    tick(1'b1, b ^ flip, 1'b0);
  endtask

  task automatic send_clean(input int n);
    repeat (n) send(1'b0);
  endtask

  // scoreboard: every flipped bit in LOCKED expects a pulse and a new count
  task automatic send_err(input logic flip);
    send(flip);
    if (flip) begin
      if (errs < 255) errs++;
      exp_q.push_back(8'(errs));
    end
    if (err_pulse || flip) begin
      check("err_pulse", int'(err_pulse), int'(flip));
      if (exp_q.size() != 0) check("err_count_sb", int'(err_count), int'(exp_q.pop_front()));
    end
  endtask

  initial begin
    int p1;
    int p2;
    int pc;
    int nbits;
    int pulses;
    logic b;

    // reset state
    do_reset();
    check("rst_state", int'(state), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err_pulse", int'(err_pulse), 0);
    check("rst_period", int'(period), 0);
    check("rst_err_count", int'(err_count), 0);

    // constant-zero input never leaves HUNT, with idle and clear cycles mixed in
    for (int i = 0; i < 24; i++) begin
      zvec[i].en        = (i % 3 != 2);
      zvec[i].d         = 1'b0;
      zvec[i].clr       = (i == 7) || (i == 19);
      zvec[i].exp_state = 2'b00;
    end
    for (int i = 0; i < 24; i++) begin
      tick(zvec[i].en, zvec[i].d, zvec[i].clr);
      check("zero_state", int'(state), int'(zvec[i].exp_state));
    end
    repeat (40) tick(1'b1, 1'b0, 1'b0);
    check("zero_long_state", int'(state), 0);

    // clean stream from seed 7FFF: SYNC after 15 bits, LOCKED after 31
    do_reset();
    for (int i = 0; i < 31; i++) begin
      lvec[i].en        = 1'b1;
      lvec[i].d         = gen_bit();
      lvec[i].clr       = 1'b0;
      lvec[i].exp_state = (i < 14) ? 2'b00 : (i < 30) ? 2'b01 : 2'b10;
    end
    for (int i = 0; i < 31; i++) begin
      tick(lvec[i].en, lvec[i].d, lvec[i].clr);
      check("lock_state", int'(state), int'(lvec[i].exp_state));
    end
    check("lock_locked", int'(locked), 1);

    // period pulses once every 32767 accepted bits
    nbits = 31;
    p1 = -1;
    p2 = -1;
    pc = 0;
    while (nbits < 65534) begin
      send(1'b0);
      nbits++;
      if (period) begin
        pc++;
        if (p1 < 0) p1 = nbits;
        else p2 = nbits;
      end
    end
    check("period_first", p1, 32767);
    check("period_second", p2, 65534);
    check("period_count", pc, 2);
    check("clean_err_count", int'(err_count), 0);
    check("clean_locked", int'(locked), 1);

    // three isolated flips: three pulses, stays LOCKED
    for (int k = 0; k < 3; k++) begin
      repeat (9) send_err(1'b0);
      send_err(1'b1);
      check("three_flip_state", int'(state), 2);
    end
    send_err(1'b0);
    check("three_err_count", int'(err_count), 3);
    check("three_sb_empty", exp_q.size(), 0);

    // flip during SYNC returns to HUNT, relock 31 clean bits later
    do_reset();
    send_clean(15);
    check("sync_entry", int'(state), 1);
    send_clean(5);
    send(1'b1);
    check("sync_flip_state", int'(state), 0);
    check("sync_flip_no_pulse", int'(err_pulse), 0);
    send_clean(30);
    check("sync_relock_before", int'(state), 1);
    send(1'b0);
    check("sync_relock", int'(state), 2);
    check("sync_err_count", int'(err_count), 0);

    // 8 errors in one window lose lock on the 8th
    do_reset();
    send_clean(31);
    check("loss_pre_lock", int'(locked), 1);
    for (int j = 0; j <= 38; j++) begin
      send_err((j >= 3) && ((j - 3) % 5 == 0));
      if (j == 33) check("loss_after_7", int'(state), 2);
    end
    check("loss_state", int'(state), 0);
    check("loss_locked", int'(locked), 0);
    check("loss_err_count", int'(err_count), 8);
    send_clean(30);
    check("relock_before", int'(locked), 0);
    send(1'b0);
    check("relock_state", int'(state), 2);
    check("relock_err_count_kept", int'(err_count), 8);

    // 7 errors at the end of a window plus 2 after the wrap: lock kept
    for (int j = 0; j < 70; j++) begin
      send_err(((j >= 56) && (j <= 62)) || (j == 64) || (j == 65));
    end
    check("wrap_state", int'(state), 2);
    check("wrap_err_count", int'(err_count), 17);

    // alternate bit_en: lock timing counted in accepted bits only
    do_reset();
    for (int i = 0; i < 31; i++) begin
      send(1'b0);
      check("alt_state", int'(state), (i < 14) ? 0 : (i < 30) ? 1 : 2);
      tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      check("alt_idle_state", int'(state), (i < 14) ? 0 : (i < 30) ? 1 : 2);
    end

    // 300 errors saturate the count at 255
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      repeat (9) send_err(1'b0);
      send_err(1'b1);
      if (err_pulse) pulses++;
    end
    check("sat_pulses", pulses, 300);
    check("sat_err_count", int'(err_count), 255);
    check("sat_locked", int'(locked), 1);

    // clr_cnt wins over a coincident error
    send_clean(9);
    b = gen_bit();
    tick(1'b1, ~b, 1'b1);
    errs = 0;
    check("clr_coincident_count", int'(err_count), 0);
    check("clr_coincident_pulse", int'(err_pulse), 1);
    tick(1'b0, 1'b0, 1'b0);
    check("pulse_deassert", int'(err_pulse), 0);
    send_clean(9);
    send_err(1'b1);
    check("count_after_clr", int'(err_count), 1);
    tick(1'b0, 1'b0, 1'b1);
    check("clr_idle_count", int'(err_count), 0);

    // async reset between edges while LOCKED with a pulse pending
    send_clean(9);
    send(1'b1);
    check("pre_rst_pulse", int'(err_pulse), 1);
    check("pre_rst_locked", int'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_locked", int'(locked), 0);
    check("async_rst_pulse", int'(err_pulse), 0);
    check("async_rst_count", int'(err_count), 0);
    check("async_rst_period", int'(period), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_clean(14);
    check("post_rst_hunt", int'(state), 0);
    send(1'b0);
    check("post_rst_sync", int'(state), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
